// File: rtl/fifo_reg_multi.sv
// Multi-channel single-clock register FIFO: NUM_CHANNELS independent queues that share
// one write port and one read port, with occupancy, threshold flags and sticky error flags.
module fifo_reg_multi #(
  parameter int WIDTH        = 8,
  parameter int LOG2_DEPTH   = 3,
  parameter int NUM_CHANNELS = 4,
  parameter int AF_THRESHOLD = (2**LOG2_DEPTH) - 2,
  localparam int DEPTH       = 2**LOG2_DEPTH,
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CNT_W       = LOG2_DEPTH + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [CW-1:0]                 wchan,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          re,
  input  logic [CW-1:0]                 rchan,
  output logic [WIDTH-1:0]              rdata,
  output logic                          rvalid,
  output logic [CW-1:0]                 rtag,
  output logic [NUM_CHANNELS*CNT_W-1:0] count,
  output logic [NUM_CHANNELS-1:0]       empty,
  output logic [NUM_CHANNELS-1:0]       full,
  output logic [NUM_CHANNELS-1:0]       almostfull,
  output logic [NUM_CHANNELS-1:0]       overflow,
  output logic [NUM_CHANNELS-1:0]       underflow,
  input  logic                          clear_err
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESHOLD);

  logic [WIDTH-1:0]      mem_q [NUM_CHANNELS][DEPTH];
  logic [LOG2_DEPTH-1:0] wptr_q  [NUM_CHANNELS];
  logic [LOG2_DEPTH-1:0] wptr_d  [NUM_CHANNELS];
  logic [LOG2_DEPTH-1:0] rptr_q  [NUM_CHANNELS];
  logic [LOG2_DEPTH-1:0] rptr_d  [NUM_CHANNELS];
  logic [CNT_W-1:0]      count_q [NUM_CHANNELS];
  logic [CNT_W-1:0]      count_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] overflow_q, overflow_d;
  logic [NUM_CHANNELS-1:0] underflow_q, underflow_d;
  logic [NUM_CHANNELS-1:0] wr_acc, rd_acc;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [CW-1:0]         rtag_q, rtag_d;
  logic                  rvalid_q, rvalid_d;

  // Channel selects are decoded by equality against each legal index, so an
  // out-of-range select matches no channel and is ignored without error.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_acc      = '0;
    rd_acc      = '0;
    overflow_d  = clear_err ? '0 : overflow_q;
    underflow_d = clear_err ? '0 : underflow_q;
    rdata_d     = rdata_q;
    rtag_d      = rtag_q;
    rvalid_d    = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      count_d[i] = count_q[i];

      rd_acc[i] = re && (rchan == CW'(i)) && (count_q[i] != '0);
      // A full channel still takes a write when the same cycle frees a slot in it.
      wr_acc[i] = we && (wchan == CW'(i)) && ((count_q[i] != DEPTH_CNT) || rd_acc[i]);

      if (we && (wchan == CW'(i)) && !wr_acc[i]) overflow_d[i] = 1'b1;
      if (re && (rchan == CW'(i)) && !rd_acc[i]) underflow_d[i] = 1'b1;

      if (wr_acc[i]) wptr_d[i] = wptr_q[i] + LOG2_DEPTH'(1);
      if (rd_acc[i]) begin
        rptr_d[i] = rptr_q[i] + LOG2_DEPTH'(1);
        rdata_d   = mem_q[i][rptr_q[i]];
        rtag_d    = rchan;
        rvalid_d  = 1'b1;
      end

      if (wr_acc[i] && !rd_acc[i])      count_d[i] = count_q[i] + CNT_W'(1);
      else if (rd_acc[i] && !wr_acc[i]) count_d[i] = count_q[i] - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      overflow_q  <= '0;
      underflow_q <= '0;
      rdata_q     <= '0;
      rtag_q      <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        count_q[i] <= count_d[i];
      end
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rdata_q     <= rdata_d;
      rtag_q      <= rtag_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // NOTE: the storage array has no reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (wr_acc[i]) mem_q[i][wptr_q[i]] <= wdata;
    end
  end

  always_comb begin
    count      = '0;
    empty      = '0;
    full       = '0;
    almostfull = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      count[i*CNT_W +: CNT_W] = count_q[i];
      empty[i]      = (count_q[i] == '0);
      full[i]       = (count_q[i] == DEPTH_CNT);
      almostfull[i] = (count_q[i] >= AF_CNT);
    end
  end

  assign rdata     = rdata_q;
  assign rtag      = rtag_q;
  assign rvalid    = rvalid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_reg_multi.sv
// Directed bench for fifo_reg_multi at default parameters (WIDTH=8, DEPTH=8, 4 channels,
// almost-full threshold 6); expected values are hand-computed per step.
module tb_fifo_reg_multi;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we, re, clear_err;
  logic [1:0]  wchan, rchan;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [1:0]  rtag;
  logic [15:0] count;
  logic [3:0]  empty, full, almostfull, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  fifo_reg_multi dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .we         (we),
    .wchan      (wchan),
    .wdata      (wdata),
    .re         (re),
    .rchan      (rchan),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rtag       (rtag),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almostfull (almostfull),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    wchan = '0; rchan = '0; wdata = '0;

    // Reset state
    #22;
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_af", 32'(almostfull), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rtag", 32'(rtag), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_udf", 32'(underflow), 32'h0);
    #1 reset_n = 1'b1;
    cycle();

    // Fill channel 0 with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wchan = 2'd0; wdata = 8'(8'h10 + i);
      cycle();
      check("fill_cnt", 32'(cnt(0)), 32'(i + 1));
      check("fill_af", 32'(almostfull[0]), 32'((i + 1) >= 6));
      check("fill_full", 32'(full[0]), 32'(i == 7));
    end
    idle();

    // Drain channel 0 in order
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; rchan = 2'd0;
      cycle();
      check("drain_rvalid", 32'(rvalid), 32'h1);
      check("drain_rdata", 32'(rdata), 32'(8'h10 + i));
      check("drain_rtag", 32'(rtag), 32'h0);
      check("drain_af", 32'(almostfull[0]), 32'((7 - i) >= 6));
    end
    idle();
    cycle();
    check("drain_pulse", 32'(rvalid), 32'h0);
    check("drain_empty", 32'(empty[0]), 32'h1);
    check("drain_hold", 32'(rdata), 32'h17);

    // Channel isolation: interleave channels 1 and 2
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; wchan = 2'd1; wdata = 8'(8'hA0 + i);
      cycle();
      wchan = 2'd2; wdata = 8'(8'hB0 + i);
      cycle();
    end
    idle();
    check("iso_cnt1", 32'(cnt(1)), 32'h4);
    check("iso_cnt2", 32'(cnt(2)), 32'h4);
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; rchan = 2'd2;
      cycle();
      check("iso_b_data", 32'(rdata), 32'(8'hB0 + i));
      check("iso_b_tag", 32'(rtag), 32'h2);
    end
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; rchan = 2'd1;
      cycle();
      check("iso_a_data", 32'(rdata), 32'(8'hA0 + i));
      check("iso_a_tag", 32'(rtag), 32'h1);
    end
    idle();
    check("iso_cnt3", 32'(cnt(3)), 32'h0);
    check("iso_empty", 32'(empty), 32'hF);

    // Full boundary on channel 0
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wchan = 2'd0; wdata = 8'(8'h20 + i);
      cycle();
    end
    check("full_flag", 32'(full[0]), 32'h1);
    wdata = 8'h99;
    cycle();
    check("full_drop_ovf", 32'(overflow), 32'h1);
    check("full_drop_cnt", 32'(cnt(0)), 32'h8);
    wdata = 8'h28; re = 1'b1; rchan = 2'd0;
    cycle();
    check("full_wr_rd_rvalid", 32'(rvalid), 32'h1);
    check("full_wr_rd_data", 32'(rdata), 32'h20);
    check("full_wr_rd_cnt", 32'(cnt(0)), 32'h8);
    check("full_wr_rd_ovf", 32'(overflow), 32'h1);
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("full_drain", 32'(rdata), 32'(8'h21 + i));
    end
    idle();
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    check("ovf_clear", 32'(overflow), 32'h0);
    check("full_empty", 32'(empty[0]), 32'h1);

    // Empty boundary on channel 3: simultaneous re+we, no bypass
    we = 1'b1; wchan = 2'd3; wdata = 8'h55; re = 1'b1; rchan = 2'd3;
    cycle();
    idle();
    check("empty_rvalid", 32'(rvalid), 32'h0);
    check("empty_udf", 32'(underflow), 32'h8);
    check("empty_cnt", 32'(cnt(3)), 32'h1);
    check("empty_hold", 32'(rdata), 32'h28);
    clear_err = 1'b1;
    cycle();
    check("udf_clear", 32'(underflow), 32'h0);
    // Set wins over clear in the same cycle
    re = 1'b1; rchan = 2'd2;
    cycle();
    idle();
    check("udf_set_wins", 32'(underflow), 32'h4);
    re = 1'b1; rchan = 2'd3;
    cycle();
    idle();
    check("ch3_data", 32'(rdata), 32'h55);
    check("ch3_tag", 32'(rtag), 32'h3);

    // Pointer wrap on channel 2: 20 write/read pairs
    we = 1'b1; wchan = 2'd2; wdata = 8'h40;
    cycle();
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; wchan = 2'd2; wdata = 8'(8'h41 + i); re = 1'b1; rchan = 2'd2;
      cycle();
      check("wrap_data", 32'(rdata), 32'(8'h40 + i));
      check("wrap_cnt", 32'(cnt(2)), 32'h1);
    end
    idle();
    we = 1'b1; wchan = 2'd2; wdata = 8'h60;
    cycle();
    wdata = 8'h61;
    cycle();
    idle();
    check("wrap_cnt3", 32'(cnt(2)), 32'h3);

    // Read pending, then asynchronous reset mid-stream
    re = 1'b1; rchan = 2'd2;
    cycle();
    check("pre_rst_rvalid", 32'(rvalid), 32'h1);
    check("pre_rst_data", 32'(rdata), 32'h54);
    reset_n = 1'b0;
    #1;
    check("async_cnt", 32'(count), 32'h0);
    check("async_empty", 32'(empty), 32'hF);
    check("async_rvalid", 32'(rvalid), 32'h0);
    check("async_rdata", 32'(rdata), 32'h0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check("post_rst_cnt", 32'(cnt(2)), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_reg_multi.md
# fifo_reg_multi

Multi-channel, single-clock register FIFO: NUM_CHANNELS independent FIFOs of 2**LOG2_DEPTH entries each, with one write port and one read port that select a channel per cycle. It is the parametrised successor of the single-channel register FIFO. It adds the following:
- full-depth occupancy;
- a programmable almost-full threshold;
- explicit full flags;
- a channel tag on read data;
- sticky overflow/underflow error flags.

It sits between pipeline stages that time-multiplex several logical streams over one datapath.

## Interface
Parameters:
- WIDTH, 8, data word width
- LOG2_DEPTH, 3, log2 of per-channel depth; DEPTH = 2**LOG2_DEPTH, minimum 1
- NUM_CHANNELS, 4, number of independent channels, minimum 1
- CW, $clog2(NUM_CHANNELS) (minimum 1), channel-select width; derived, not overridden
- AF_THRESHOLD, DEPTH-2, almostfull asserts when count >= AF_THRESHOLD; legal range 1..DEPTH

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- we  in  1  write request
- wchan  in  CW  channel written
- wdata  in  WIDTH  write data
- re  in  1  read request
- rchan  in  CW  channel read
- rdata  out  WIDTH  read data, registered
- rvalid  out  1  rdata valid this cycle
- rtag  out  CW  channel of current rdata
- count  out  NUM_CHANNELS*(LOG2_DEPTH+1)  per-channel occupancy; channel i at bits [i*(LOG2_DEPTH+1) +: LOG2_DEPTH+1]
- empty  out  NUM_CHANNELS  count==0 per channel
- full  out  NUM_CHANNELS  count==DEPTH per channel
- almostfull  out  NUM_CHANNELS  count>=AF_THRESHOLD per channel
- overflow  out  NUM_CHANNELS  sticky: a write to that channel was dropped
- underflow  out  NUM_CHANNELS  sticky: a read to that channel was rejected
- clear_err  in  1  synchronous clear of overflow and underflow

## Operation
- Storage: NUM_CHANNELS×DEPTH×WIDTH register array. Each channel has a LOG2_DEPTH-bit wptr and rptr, both wrapping modulo DEPTH, plus a (LOG2_DEPTH+1)-bit count.
- Write accepted iff we && (!full[wchan] || (re && rchan==wchan && !empty[wchan])).
  - Accepted write: store wdata at mem[wchan][wptr]; wptr+1.
  - Rejected write: data dropped; overflow[wchan] set.
- Read accepted iff re && !empty[rchan].
  - Accepted read: rdata <= mem[rchan][rptr]; rtag <= rchan; rvalid <= 1; rptr+1.
  - Rejected read: underflow[rchan] set; rvalid <= 0.
  - A write to an empty channel in the same cycle does not make the read accepted; the written data is not bypassed.
- Count per channel:
  - +1 on accepted write only.
  - −1 on accepted read only.
  - Unchanged when both are accepted on the same channel, or when neither is.
  - Writes and reads to different channels update their channels independently in the same cycle.
- Outputs empty, full and almostfull are combinational decodes of the registered count.
- Out-of-range wchan/rchan (≥ NUM_CHANNELS, non-power-of-2 channel count):
  - request ignored;
  - no state change;
  - no error flag set.
- clear_err: clears all sticky flags. If an error event occurs in the same cycle, the set wins for that bit.
- rdata and rtag update only on an accepted read and hold otherwise.

## Timing
- Read latency 1: an accepted read at edge N presents rdata/rtag/rvalid after edge N. rvalid is a single-cycle pulse per accepted read.
- Back-to-back reads are sustained at one per cycle, on any mix of channels.
- Write-to-read latency 1: data written at edge N is readable by a request sampled at edge N+1.
- Flags reflect the count after each edge. There is no look-ahead.
- Reset: while reset_n is low, all of the following hold asynchronously:
  - wptr, rptr, count = 0;
  - empty = all 1; full = 0; almostfull = 0 (AF_THRESHOLD ≥ 1);
  - rvalid = 0; rdata = 0; rtag = 0;
  - overflow = 0; underflow = 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all contents. An rvalid pending from the prior edge is dropped.

## Test plan
- Fill/drain, DEPTH=8, channel 0: 8 writes 0x10..0x17, then 8 reads. Required: full=1 after the 8th write; reads return 0x10..0x17 in order, rtag=0, one cycle after each re; empty=1 at the end.
- Channel isolation: interleave writes A0..A3 to channel 1 and B0..B3 to channel 2, then read channel 2 then channel 1. Required: B0..B3 with rtag=2, then A0..A3 with rtag=1; count of channel 3 stays 0.
- Full boundary, channel 0 full:
  - write alone: dropped, overflow[0]=1, count=8;
  - next cycle write+read on channel 0: both accepted, count=8, the new word appears last.
- Empty boundary, channel 3 empty: re+we to channel 3 in the same cycle. Required: rvalid=0, underflow[3]=1, count=1. clear_err next cycle clears underflow.
- Almostfull, AF_THRESHOLD=6: almostfull rises on the 6th write and falls on the first read from count 6.
- Wrap and reset: 20 write/read pairs on one channel exercise pointer wrap with data order intact. Then drop reset_n mid-stream with 3 entries held. Required: count=0, empty=1, rvalid=0 immediately, with no clock edge needed.
